// File: rtl/resta_div_ctrl.sv
// resta_div_ctrl: unsigned N-bit divider using repeated subtraction.
//
// A single magnitude subtractor compares the running remainder against the
// latched divisor. Each RUN cycle either subtracts once and counts one, or
// finishes when the remainder has dropped below the divisor.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  request a division (accepted only in IDLE)
//   A, B   dividend / divisor, unsigned, sampled when start is accepted
//   busy   high while the division is iterating (RUN)
//   done   one-cycle pulse; Q, Rem, div0 valid
//   Q      quotient
//   Rem    remainder
//   div0   last accepted request had B == 0 (Q = all ones, Rem = A)

// N-bit magnitude subtractor: neg flags minuend < subtrahend.
module resta_mag_sub #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] r,
  output logic         neg
);

  logic [N:0] diff;

  // The extra top bit is the borrow out of the subtraction.
  assign diff = {1'b0, a} - {1'b0, b};
  assign r    = diff[N-1:0];
  assign neg  = diff[N];

endmodule

module resta_div_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] Rem,
  output logic         div0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic [N-1:0] rem, rem_nx;
  logic [N-1:0] d, d_nx;
  logic [N-1:0] q, q_nx;
  logic         div0_r, div0_nx;

  logic [N-1:0] sub_r;
  logic         sub_neg;

  resta_mag_sub #(.N(N)) u_sub (
    .a   (rem),
    .b   (d),
    .r   (sub_r),
    .neg (sub_neg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      d      <= '0;
      q      <= '0;
      div0_r <= 1'b0;
    end else begin
      state  <= state_nx;
      rem    <= rem_nx;
      d      <= d_nx;
      q      <= q_nx;
      div0_r <= div0_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    d_nx     = d;
    q_nx     = q;
    div0_nx  = div0_r;
    case (state)
      IDLE: begin
        if (start) begin
          rem_nx = A;
          d_nx   = B;
          if (B == '0) begin
            // Divide by zero skips RUN and reports all-ones quotient.
            q_nx     = '1;
            div0_nx  = 1'b1;
            state_nx = DONE;
          end else begin
            q_nx     = '0;
            div0_nx  = 1'b0;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        // Equal operands give neg=0, so rem==d still counts one more.
        // q cannot wrap: with d>=1 at most 2^N-1 subtractions fit.
        if (!sub_neg) begin
          rem_nx = sub_r;
          q_nx   = q + N'(1);
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign Q    = q;
  assign Rem  = rem;
  assign div0 = div0_r;

endmodule

// File: tb/tb_resta_div_ctrl.sv
// Testbench for resta_div_ctrl (N=4): directed divisions with literal
// expectations plus a per-cycle comparison against an arithmetic model.
module tb_resta_div_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] Rem;
  logic         div0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  resta_div_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .Rem   (Rem),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 dividing, 2 result pulse. After k subtraction
  // steps the quotient is k and the remainder A - k*B; it finishes when k
  // reaches A/B.
  int m_ph = 0, m_a = 0, m_b = 0, m_k = 0;
  int m_q = 0, m_rem = 0, m_div0 = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_q = 0; m_rem = 0; m_div0 = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_a = int'(A);
          m_b = int'(B);
          if (m_b == 0) begin
            m_ph = 2; m_q = (1 << N) - 1; m_rem = m_a; m_div0 = 1;
          end else begin
            m_ph = 1; m_k = 0; m_q = 0; m_rem = m_a; m_div0 = 0;
          end
        end
        1: begin
          if (m_k == m_a / m_b) m_ph = 2;
          else begin
            m_k++;
            m_q = m_k;
            m_rem = m_a - m_k * m_b;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", int'(busy), int'(m_ph == 1));
      chk("model_done", int'(done), int'(m_ph == 2));
      chk("model_Q", int'(Q), m_q);
      chk("model_Rem", int'(Rem), m_rem);
      chk("model_div0", int'(div0), m_div0);
    end
  end

  // Call at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic do_div(input int a, input int b, input int eq, input int erem,
                        input int ediv0, input int elat, input bit hold);
    int lat = 0;
    int busyc = 0;
    bit seen = 0;
    A = N'(a);
    B = N'(b);
    start = 1'b1;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (hold) begin
        A = N'($urandom_range((1 << N) - 1));
        B = N'($urandom_range((1 << N) - 1));
      end else begin
        start = 1'b0;
      end
      if (busy) busyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk($sformatf("seen_done_%0d_%0d", a, b), int'(seen), 1);
    chk($sformatf("latency_%0d_%0d", a, b), lat, elat);
    chk($sformatf("busy_cycles_%0d_%0d", a, b), busyc, elat - 1);
    chk($sformatf("Q_%0d_%0d", a, b), int'(Q), eq);
    chk($sformatf("Rem_%0d_%0d", a, b), int'(Rem), erem);
    chk($sformatf("div0_%0d_%0d", a, b), int'(div0), ediv0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    // Start ignored while reset is high.
    start = 1'b1; A = 4'd13; B = 4'd4;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_Q", int'(Q), 0);
    chk("rst_Rem", int'(Rem), 0);
    chk("rst_div0", int'(div0), 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    do_div(13, 4, 3, 1, 0, 5, 0);
    @(negedge clk);
    chk("hold_Q_idle", int'(Q), 3);
    chk("hold_Rem_idle", int'(Rem), 1);
    do_div(4, 4, 1, 0, 0, 3, 0);
    @(negedge clk);
    do_div(3, 7, 0, 3, 0, 2, 0);
    @(negedge clk);
    do_div(15, 1, 15, 0, 0, 17, 0);
    @(negedge clk);
    do_div(9, 0, 15, 9, 1, 1, 0);
    @(negedge clk);
    do_div(0, 5, 0, 0, 0, 2, 0);
    @(negedge clk);
    do_div(15, 15, 1, 0, 0, 3, 0);
    @(negedge clk);
    // start held with operands scrambled throughout the run.
    do_div(13, 4, 3, 1, 0, 5, 1);
    @(negedge clk);
    chk("after_hold_idle_busy", int'(busy), 0);

    // Reset during the second RUN cycle of 13/4.
    A = 4'd13; B = 4'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_busy", int'(busy), 1);
    chk("midrun_Q", int'(Q), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_Q", int'(Q), 0);
    chk("midrst_Rem", int'(Rem), 0);
    chk("midrst_div0", int'(div0), 0);
    rst = 1'b0;
    do_div(6, 2, 3, 0, 0, 5, 0);
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
